// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the MEM stage: default datapath width,
// load/store funct3 encodings, MEM-stage FSM state encoding and the
// alignment rule shared by RTL consumers.
package mem_access_unit_pkg;

  localparam int DATAWIDTH = 32;

  // funct3 access size/sign encodings (loads and stores share B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mem_state_t;

  // Halfword needs addr[0]=0, word needs addr[1:0]=0; the size is taken
  // from funct3[1:0] so signed/unsigned variants share the rule.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
           ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_store_align.sv
// load_store_align: purely combinational lane handling for the MEM stage.
//   i_funct3    access size/sign
//   i_addr_lo   byte offset within the word
//   i_wr_data   store data (low byte/half used for SB/SH)
//   i_rd_data   word returned by data memory
//   o_be        byte enables for stores
//   o_wdata     store data replicated across all lanes
//   o_load_data extracted and sign/zero-extended load result
//   o_misalign  access violates natural alignment
module load_store_align
  import mem_access_unit_pkg::*;
#(
  parameter int DW = DATAWIDTH
) (
  input  logic [2:0]    i_funct3,
  input  logic [1:0]    i_addr_lo,
  input  logic [DW-1:0] i_wr_data,
  input  logic [DW-1:0] i_rd_data,
  output logic [3:0]    o_be,
  output logic [DW-1:0] o_wdata,
  output logic [DW-1:0] o_load_data,
  output logic          o_misalign
);

  logic [DW-1:0] w_lane;

  // Shift the addressed lane down to bit 0 so extraction is offset-free.
  assign w_lane     = i_rd_data >> {i_addr_lo, 3'b000};
  assign o_misalign = is_misaligned(i_funct3, i_addr_lo);

  // Store side: unsigned encodings are meaningless for stores and fall
  // into the full-word default together with the undefined codes.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wr_data;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {(DW/8){i_wr_data[7:0]}};
      end
      F3_H: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {(DW/16){i_wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_load_data = i_rd_data;
    case (i_funct3)
      F3_B:  o_load_data = {{(DW-8){w_lane[7]}}, w_lane[7:0]};
      F3_H:  o_load_data = {{(DW-16){w_lane[15]}}, w_lane[15:0]};
      F3_BU: o_load_data = {{(DW-8){1'b0}}, w_lane[7:0]};
      F3_HU: o_load_data = {{(DW-16){1'b0}}, w_lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage. Issues data-memory requests for
// loads/stores, stalls the pipeline until the memory acknowledges (or a
// timeout expires), and registers the MEM/WB outputs.
//   clk, rst_n                      clock / async active-low reset
//   Branch..RegWrite, rd, ALU_result,
//   wr_MemData, PC_imm, PC_branch,
//   funct3                          EX/MEM register contents
//   dmem_*                          data memory request/response
//   mem_stall                       holds EX/MEM and earlier stages
//   branch_taken, branch_target     combinational branch resolution
//   *_o, load_data_o                MEM/WB register
//   misalign_o, bus_err_o           one-cycle fault pulses
//
// state  | meaning
// IDLE   | no access outstanding; aligned access raises req and stall
// BUSY   | request held stable, waiting for dmem_ack or timeout
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DW      = DATAWIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Branch,
  input  logic          MemRead,
  input  logic          MemtoReg,
  input  logic          MemWrite,
  input  logic          RegWrite,
  input  logic [DW-1:0] PC_imm,
  input  logic [4:0]    rd,
  input  logic [DW-1:0] ALU_result,
  input  logic [DW-1:0] wr_MemData,
  input  logic          PC_branch,
  input  logic [2:0]    funct3,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          mem_stall,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target,
  output logic          RegWrite_o,
  output logic          MemtoReg_o,
  output logic [4:0]    rd_o,
  output logic [DW-1:0] ALU_result_o,
  output logic [DW-1:0] load_data_o,
  output logic          misalign_o,
  output logic          bus_err_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_t    r_state, w_next;
  logic [CW-1:0] r_cnt;

  logic          w_access, w_misalign;
  logic          w_req, w_stall, w_ack_hit, w_timeout, w_misal_hit;
  logic [3:0]    w_be;
  logic [DW-1:0] w_wdata, w_load;

  load_store_align #(.DW(DW)) u_align (
    .i_funct3    (funct3),
    .i_addr_lo   (ALU_result[1:0]),
    .i_wr_data   (wr_MemData),
    .i_rd_data   (dmem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load),
    .o_misalign  (w_misalign)
  );

  assign w_access      = MemRead | MemWrite;
  assign branch_taken  = Branch & PC_branch;
  assign branch_target = PC_imm;

  // Request/stall are gated by rst_n so they drop the instant reset asserts,
  // even while the EX/MEM register still presents an access.
  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_ack_hit   = 1'b0;
    w_timeout   = 1'b0;
    w_misal_hit = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_misalign) begin
              w_misal_hit = 1'b1;
            end else begin
              w_req   = 1'b1;
              w_stall = 1'b1;
              w_next  = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            w_req     = 1'b1;
            w_ack_hit = 1'b1;
            w_next    = S_IDLE;
          end else if (r_cnt == '0) begin
            // Terminal count: release the pipeline and flag the fault.
            w_timeout = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_req   = 1'b1;
            w_stall = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign dmem_req   = w_req;
  assign mem_stall  = w_stall;
  assign dmem_we    = w_req & MemWrite & ~MemRead;
  assign dmem_addr  = {ALU_result[DW-1:2], 2'b00};
  assign dmem_be    = w_req ? w_be : 4'b0000;
  assign dmem_wdata = w_req ? w_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Down-counter loaded on entry so the TIMEOUT-th BUSY cycle sees zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= (w_next == S_BUSY) ? CW'(TIMEOUT - 1) : '0;
    end else if (w_next == S_IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // MEM/WB register: a stalled edge retires nothing, so RegWrite_o is
  // cleared to avoid writing the same instruction back twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_o   <= 1'b0;
      MemtoReg_o   <= 1'b0;
      rd_o         <= '0;
      ALU_result_o <= '0;
      load_data_o  <= '0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else if (w_stall) begin
      RegWrite_o <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      RegWrite_o   <= RegWrite & ~w_misal_hit & ~w_timeout;
      MemtoReg_o   <= MemtoReg;
      rd_o         <= rd;
      ALU_result_o <= ALU_result;
      load_data_o  <= (w_ack_hit && MemRead) ? w_load : '0;
      misalign_o   <= w_misal_hit;
      bus_err_o    <= w_timeout;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Branch, MemRead, MemtoReg, MemWrite, RegWrite, PC_branch;
  logic [DW-1:0] PC_imm, ALU_result, wr_MemData, dmem_rdata;
  logic [4:0]    rd;
  logic [2:0]    funct3;
  logic          dmem_ack;
  logic          dmem_req, dmem_we, mem_stall, branch_taken;
  logic [DW-1:0] dmem_addr, dmem_wdata, branch_target, ALU_result_o, load_data_o;
  logic [3:0]    dmem_be;
  logic          RegWrite_o, MemtoReg_o, misalign_o, bus_err_o;
  logic [4:0]    rd_o;

  mem_access_unit #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .RegWrite(RegWrite),
    .PC_imm(PC_imm), .rd(rd), .ALU_result(ALU_result),
    .wr_MemData(wr_MemData), .PC_branch(PC_branch), .funct3(funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .branch_taken(branch_taken),
    .branch_target(branch_target),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .rd_o(rd_o),
    .ALU_result_o(ALU_result_o), .load_data_o(load_data_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic tb_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic m_mis(input logic [2:0] f3, input logic [1:0] a);
    if (f3[1:0] == 2'b01) return a[0];
    if (f3[1:0] == 2'b10) return a != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b001: return {{16{h[15]}}, h};
      3'b100: return {24'h0, b};
      3'b101: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'b000) begin
      case (a)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (f3 == 3'b001) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'b000) return {4{d[7:0]}};
    if (f3 == 3'b001) return {2{d[15:0]}};
    return d;
  endfunction

  task automatic clear_inputs();
    Branch = 0; MemRead = 0; MemtoReg = 0; MemWrite = 0; RegWrite = 0;
    PC_branch = 0; PC_imm = '0; ALU_result = '0; wr_MemData = '0;
    rd = '0; funct3 = '0; dmem_ack = 0; dmem_rdata = '0;
  endtask

  // Called at a falling edge. ack_at counts cycles from the request cycle
  // (0); a negative value means the memory never answers.
  task automatic issue(input logic rdf, input logic wrf, input logic rw,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdat, input logic [31:0] rdat,
                       input int ack_at, input logic [4:0] rdn, output int stalls);
    exp_t e;
    logic acc, mis, tmo;
    int   c;
    bit   done;
    MemRead = rdf; MemWrite = wrf; RegWrite = rw; MemtoReg = rdf;
    funct3 = f3; ALU_result = addr; wr_MemData = wdat; rd = rdn;
    dmem_ack = 0; dmem_rdata = rdat; tb_valid = 1;
    acc = rdf | wrf;
    mis = acc && m_mis(f3, addr[1:0]);
    tmo = acc && !mis && (ack_at < 0);
    e.rw   = rw && !mis && !tmo;
    e.mtr  = rdf;
    e.rd   = rdn;
    e.alu  = addr;
    e.ld   = (rdf && !mis && !tmo) ? m_load(f3, addr[1:0], rdat) : 32'h0;
    e.mis  = mis;
    e.berr = tmo;
    sb.push_back(e);
    stalls = 0;
    c = 0;
    done = 0;
    while (!done) begin
      #4;
      if (c == 0) begin
        check("req", 32'(dmem_req), 32'(acc && !mis));
        if (acc && !mis) begin
          check("addr", dmem_addr, {addr[31:2], 2'b00});
          check("we", 32'(dmem_we), 32'(wrf && !rdf));
          if (wrf && !rdf) begin
            check("be", 32'(dmem_be), 32'(m_be(f3, addr[1:0])));
            check("wdata", dmem_wdata, m_wdata(f3, wdat));
          end
        end
      end
      if (ack_at > 0 && c == ack_at) begin
        check("req_hold", 32'(dmem_req), 32'd1);
        check("addr_hold", dmem_addr, {addr[31:2], 2'b00});
      end
      if (mem_stall) stalls++;
      else done = 1;
      if (!done) begin
        if (c >= 60) begin
          check("stall_bound", 32'(mem_stall), 32'd0);
          done = 1;
        end else begin
          @(negedge clk);
          c++;
          dmem_ack = (c == ack_at);
        end
      end
    end
    @(negedge clk);
    tb_valid = 0;
    clear_inputs();
  endtask

  // Scoreboard side: an instruction retires at an edge where mem_stall was 0.
  initial begin : monitor
    logic s_v, s_st;
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      s_v  = tb_valid;
      s_st = mem_stall;
      @(posedge clk);
      #1;
      if (s_v && s_st) begin
        check("no_dup_wb", 32'(RegWrite_o), 32'd0);
      end else if (s_v) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("wb_regwrite", 32'(RegWrite_o), 32'(e.rw));
          check("wb_memtoreg", 32'(MemtoReg_o), 32'(e.mtr));
          check("wb_rd", 32'(rd_o), 32'(e.rd));
          check("wb_alu", ALU_result_o, e.alu);
          check("wb_load", load_data_o, e.ld);
          check("wb_misalign", 32'(misalign_o), 32'(e.mis));
          check("wb_bus_err", 32'(bus_err_o), 32'(e.berr));
        end
      end
    end
  end

  initial begin : stim
    int st;
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    // Present an aligned access during reset: request/stall must stay low.
    MemRead = 1; funct3 = 3'b010; ALU_result = 32'h100;
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_regwrite", 32'(RegWrite_o), 32'd0);
    check("rst_load", load_data_o, 32'h0);
    check("rst_alu", ALU_result_o, 32'h0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    @(negedge clk);

    issue(0, 0, 1, 3'b000, 32'h0000_0055, 32'h0, 32'h0, -1, 5'd5, st);
    check("alu_stalls", 32'(st), 32'd0);
    issue(1, 0, 1, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 5'd1, st);
    check("lw_stalls", 32'(st), 32'd3);
    issue(1, 0, 1, 3'b000, 32'h0000_0103, 32'h0, 32'h8000_0000, 1, 5'd2, st);
    issue(1, 0, 1, 3'b100, 32'h0000_0103, 32'h0, 32'h8000_0000, 2, 5'd3, st);
    issue(1, 0, 1, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_0000, 1, 5'd4, st);
    issue(1, 0, 1, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 4, 5'd6, st);
    issue(0, 1, 0, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 2, 5'd0, st);
    check("sh_stalls", 32'(st), 32'd2);
    issue(0, 1, 0, 3'b000, 32'h0000_0101, 32'h0000_00EF, 32'h0, 1, 5'd0, st);
    issue(1, 0, 1, 3'b111, 32'h0000_0104, 32'h0, 32'h1122_3344, 1, 5'd7, st);
    issue(1, 1, 1, 3'b010, 32'h0000_0108, 32'h5555_5555, 32'h0BAD_F00D, 1, 5'd8, st);

    issue(1, 0, 1, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 1, 5'd9, st);
    check("mis_stalls", 32'(st), 32'd0);
    @(posedge clk); #1;
    check("mis_pulse_end", 32'(misalign_o), 32'd0);
    @(negedge clk);
    issue(1, 0, 1, 3'b001, 32'h0000_0103, 32'h0, 32'h0, 1, 5'd10, st);

    issue(1, 0, 1, 3'b010, 32'h0000_0300, 32'h0, 32'h0, -1, 5'd11, st);
    check("tmo_stalls", 32'(st), 32'(TO));
    @(posedge clk); #1;
    check("tmo_pulse_end", 32'(bus_err_o), 32'd0);
    check("tmo_idle_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    issue(1, 0, 1, 3'b010, 32'h0000_0304, 32'h0, 32'h7777_0001, 1, 5'd12, st);

    // Reset in the second BUSY cycle, then a stale ack after release.
    MemRead = 1; MemtoReg = 1; RegWrite = 1; funct3 = 3'b010;
    ALU_result = 32'h0000_0200; rd = 5'd13;
    #1 check("mid_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    Branch = 1; PC_branch = 1; PC_imm = 32'h0000_0400;
    #1;
    check("mid_rst_stall", 32'(mem_stall), 32'd0);
    check("mid_rst_req", 32'(dmem_req), 32'd0);
    check("mid_rst_alu", ALU_result_o, 32'h0);
    check("mid_rst_rd", 32'(rd_o), 32'd0);
    check("br_taken_rst", 32'(branch_taken), 32'd1);
    check("br_target_rst", branch_target, 32'h0000_0400);
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    @(negedge clk);
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    dmem_ack = 0;
    #1;
    check("late_ack_regwrite", 32'(RegWrite_o), 32'd0);
    check("late_ack_load", load_data_o, 32'h0);

    // Branch resolution is combinational.
    Branch = 1; PC_branch = 0; PC_imm = 32'h0000_1230;
    #1 check("br_not_taken", 32'(branch_taken), 32'd0);
    PC_branch = 1;
    #1 check("br_taken", 32'(branch_taken), 32'd1);
    check("br_target", branch_target, 32'h0000_1230);
    clear_inputs();

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameters: DW, default `datawidth (32), datapath width; TIMEOUT, default 16, max cycles waiting on dmem_ack.
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Branch, MemRead, MemtoReg, MemWrite, RegWrite  in  1 each  control from EX/MEM register
- PC_imm  in  DW  branch target
- rd  in  5  destination register
- ALU_result  in  DW  result / memory address
- wr_MemData  in  DW  store data
- PC_branch  in  1  ALU branch condition
- funct3  in  3  access size/sign
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  DW  word-aligned address ({ALU_result[DW-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  DW  lane-replicated store data
- dmem_ack  in  1  memory response
- dmem_rdata  in  DW  read word
- mem_stall  out  1  hold EX/MEM and earlier stages
- branch_taken  out  1  Branch & PC_branch
- branch_target  out  DW  PC_imm passthrough
- RegWrite_o, MemtoReg_o  out  1 each  to WB
- rd_o  out  5  to WB
- ALU_result_o, load_data_o  out  DW each  to WB
- misalign_o, bus_err_o  out  1 each  single-cycle fault pulses

Function
REQ-003 SHALL implement FSM IDLE/BUSY; access = MemRead|MemWrite (MemRead wins if both).
REQ-004 SHALL report an access as misaligned when funct3[1:0]=01 with addr[0]=1, or 10 with addr[1:0]!=0; misaligned: no dmem_req, misalign_o=1 for one cycle at the MEM/WB capture edge, RegWrite_o=0 for that instruction.
REQ-005 SHALL, in IDLE with an aligned access, assert dmem_req combinationally, raise mem_stall, enter BUSY at the next edge.
REQ-006 SHALL hold dmem_req and all dmem_* outputs stable in BUSY until dmem_ack; mem_stall=1 in BUSY while dmem_ack=0.
REQ-007 SHALL, on dmem_ack in BUSY, drop mem_stall in that cycle, capture MEM/WB outputs at the edge, and return to IDLE; dmem_ack in IDLE SHALL be ignored.
REQ-008 SHALL count BUSY cycles; on reaching TIMEOUT without ack: drop request, pulse bus_err_o, capture with RegWrite_o=0, return to IDLE.
REQ-009 SHALL store via dmem_be: SB=0001<<addr[1:0], SH=0011<<addr[1:0], SW=1111; wdata byte/half replicated across lanes.
REQ-010 SHALL extract loads from lane addr[1:0]: LB/LH sign-extended, LBU/LHU zero-extended, LW whole word; undefined funct3 treated as LW/SW.
REQ-011 SHALL, for non-access instructions, capture MEM/WB outputs at every edge with mem_stall=0 (zero extra latency).
REQ-012 SHALL drive RegWrite_o=0 after any edge where mem_stall=1 (no duplicate writeback).
REQ-013 SHALL drive branch_taken/branch_target combinationally, unaffected by stall state.

Reset
REQ-014 SHALL on rst_n low immediately force IDLE, counter 0, all registered outputs 0, dmem_req=0, mem_stall=0.
REQ-015 SHALL abandon an in-flight access on reset mid-BUSY; a late dmem_ack after release is ignored.

Structure
REQ-016 SHALL put `datawidth, funct3 encodings and FSM state encoding in the shared pipeline package.
REQ-017 SHALL contain one sub-module, load_store_align (combinational be/wdata/load-extract), instantiated once.

Verification
REQ-018 LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> mem_stall high 3 cycles, RegWrite_o=1, load_data_o=0xDEADBEEF.
REQ-019 LB addr 0x103, rdata 0x80000000 -> load_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-020 SH addr 0x102, wr_MemData 0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-021 LW addr 0x101 -> no dmem_req, misalign_o pulse, RegWrite_o=0, mem_stall never asserted.
REQ-022 LW with no ack, TIMEOUT=16 -> bus_err_o pulse after 16 BUSY cycles, FSM IDLE, RegWrite_o=0.
REQ-023 rst_n low in 2nd BUSY cycle, ack one cycle after release -> outputs 0, no writeback; Branch=1,PC_branch=1 -> branch_taken=1 same cycle.
